// File: rtl/cordic_sweep_ctrl.sv
// rtl/cordic_sweep_ctrl.sv - degree sweep sequencer and byte packer around a CORDIC sin/cos stage
// Optional feature macro: SWEEP_CHECKSUM_EN appends an XOR checksum byte to every packet.
module cordic_sweep_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int ANGLE_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [8:0]         step,
  output logic               cordic_start,
  output logic [ANGLE_W-1:0] cordic_angle,
  input  logic [15:0]        cordic_sine,
  input  logic [15:0]        cordic_cosine,
  input  logic               cordic_done,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               timeout_err
);

  localparam int TIMER_W = $clog2(TIMEOUT) + 1;
`ifdef SWEEP_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    SEND      = 3'd4,
    ADVANCE   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [8:0]         angle_q, angle_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [2:0]         idx_q, idx_d;
  logic [15:0]        sine_q, sine_d;
  logic [15:0]        cos_q, cos_d;
  logic               timeout_err_q, timeout_err_d;

  logic [TIMER_W-1:0] timer_inc;
  logic               timer_expire;
  logic [9:0]         step_eff;
  logic [9:0]         angle_sum;
  logic [9:0]         angle_wrap;
  logic [7:0]         byte_sel;

  // The timer has reached its last allowed value when the incremented count hits TIMEOUT-1.
  assign timer_inc    = timer_q + 1'b1;
  assign timer_expire = (timer_inc == TIMER_W'(TIMEOUT - 1));

  // Steps of a full turn or more clamp to 359 so one subtraction of 360 always wraps.
  assign step_eff   = (step >= 9'd360) ? 10'd359 : {1'b0, step};
  assign angle_sum  = {1'b0, angle_q} + step_eff;
  assign angle_wrap = (angle_sum >= 10'd360) ? (angle_sum - 10'd360) : angle_sum;

  assign cordic_angle = {{(ANGLE_W-9){1'b0}}, angle_q};
  assign busy         = (state_q != IDLE);
  assign timeout_err  = timeout_err_q;

  // Pick the packet byte for the current index: sine MSB first, then cosine.
  always_comb begin
    byte_sel = 8'd0;
    case (idx_q)
      3'd0:    byte_sel = sine_q[15:8];
      3'd1:    byte_sel = sine_q[7:0];
      3'd2:    byte_sel = cos_q[15:8];
      3'd3:    byte_sel = cos_q[7:0];
`ifdef SWEEP_CHECKSUM_EN
      default: byte_sel = sine_q[15:8] ^ sine_q[7:0] ^ cos_q[15:8] ^ cos_q[7:0];
`else
      default: byte_sel = 8'd0;
`endif
    endcase
  end

  // Next-state and output logic for launch, done handshake, packet send and angle advance.
  always_comb begin
    state_d       = state_q;
    angle_d       = angle_q;
    timer_d       = timer_q;
    idx_d         = idx_q;
    sine_d        = sine_q;
    cos_d         = cos_q;
    timeout_err_d = timeout_err_q;
    cordic_start  = 1'b0;
    out_valid     = 1'b0;
    out_data      = 8'd0;
    case (state_q)
      IDLE: begin
        if (en) state_d = LAUNCH;
      end
      LAUNCH: begin
        cordic_start = 1'b1;
        timer_d      = '0;
        state_d      = WAIT_LOW;
      end
      WAIT_LOW: begin
        timer_d = timer_inc;
        if (timer_expire) begin
          timeout_err_d = 1'b1;
          state_d       = ADVANCE;
        end else if (!cordic_done) begin
          state_d = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        timer_d = timer_inc;
        if (cordic_done) begin
          sine_d  = cordic_sine;
          cos_d   = cordic_cosine;
          idx_d   = 3'd0;
          state_d = SEND;
        end else if (timer_expire) begin
          timeout_err_d = 1'b1;
          state_d       = ADVANCE;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        out_data  = byte_sel;
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = 3'd0;
            state_d = ADVANCE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ADVANCE: begin
        angle_d = angle_wrap[8:0];
        state_d = en ? LAUNCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any packet in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      angle_q       <= 9'd0;
      timer_q       <= '0;
      idx_q         <= 3'd0;
      sine_q        <= 16'd0;
      cos_q         <= 16'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      angle_q       <= angle_d;
      timer_q       <= timer_d;
      idx_q         <= idx_d;
      sine_q        <= sine_d;
      cos_q         <= cos_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_cordic_sweep_ctrl.sv
// tb/tb_cordic_sweep_ctrl.sv - randomized self-checking bench for cordic_sweep_ctrl
module tb_cordic_sweep_ctrl;

  localparam int TIMEOUT = 64;
`ifdef SWEEP_CHECKSUM_EN
  localparam int PKT = 5;
`else
  localparam int PKT = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [8:0]  step;
  logic        cordic_start;
  logic [15:0] cordic_angle;
  logic [15:0] cordic_sine;
  logic [15:0] cordic_cosine;
  logic        cordic_done;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        timeout_err;

  cordic_sweep_ctrl #(.TIMEOUT(TIMEOUT), .ANGLE_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .step          (step),
    .cordic_start  (cordic_start),
    .cordic_angle  (cordic_angle),
    .cordic_sine   (cordic_sine),
    .cordic_cosine (cordic_cosine),
    .cordic_done   (cordic_done),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_starts = 0;
  int n_bytes  = 0;

  // Reference model: next launch angle and the byte stream still owed by the DUT.
  int         exp_angle = 0;
  int         step_q[$];
  logic [7:0] exp_q[$];

  // CORDIC stub state.
  bit pend = 0, cur_to = 0, to_next = 0, to_checked = 0, fixed_vals = 0, await_first = 0;
  int tick = 0, hold = 0, lat = 0, done_cyc = 0;

  // Consumer state.
  bit         held_v = 0;
  logic [7:0] held_d = 8'd0;
  int         rdy_mode = 0, rdy_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One clock of stub CORDIC, consumer and model, evaluated at the falling edge.
  task automatic cycle();
    logic [15:0] s, c;
    bit rdy;
    @(negedge clk);
    cyc++;
    if (cordic_start) begin
      check("start_angle", cordic_angle, exp_angle);
      n_starts++;
      pend   = 1;
      tick   = 0;
      cur_to = to_next;
      to_next = 0;
      if (fixed_vals) begin
        hold = 0;
        lat  = 5;
      end else begin
        hold = $urandom_range(0, 2);
        lat  = $urandom_range(hold + 3, 8);
      end
      if (step_q.size() > 0) step = 9'(step_q.pop_front());
      else step = 9'($urandom_range(0, 511));
      exp_angle = (exp_angle + ((int'(step) > 359) ? 359 : int'(step))) % 360;
    end else if (pend) begin
      tick++;
    end
    if (pend) begin
      if (cur_to) begin
        if (tick >= hold) cordic_done = 1'b0;
        if (!to_checked && tick == TIMEOUT - 1) check("timeout_early", timeout_err, 0);
        if (!to_checked && tick == TIMEOUT) begin
          check("timeout_at_limit", timeout_err, 1);
          to_checked = 1;
        end
      end else if (tick >= lat) begin
        s = fixed_vals ? 16'h1234 : 16'($urandom);
        c = fixed_vals ? 16'hABCD : 16'($urandom);
        cordic_sine   = s;
        cordic_cosine = c;
        cordic_done   = 1'b1;
        pend = 0;
        exp_q.push_back(s[15:8]);
        exp_q.push_back(s[7:0]);
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[7:0]);
`ifdef SWEEP_CHECKSUM_EN
        exp_q.push_back(s[15:8] ^ s[7:0] ^ c[15:8] ^ c[7:0]);
`endif
        done_cyc    = cyc;
        await_first = 1;
      end else if (tick >= hold) begin
        cordic_done   = 1'b0;
        cordic_sine   = 16'($urandom);
        cordic_cosine = 16'($urandom);
      end
    end

    if (held_v) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, held_d);
    end
    held_v = 0;
    case (rdy_mode)
      0:       rdy = ((rdy_cnt % 4) == 0) || ((rdy_cnt % 4) == 3);
      1:       rdy = ($urandom_range(0, 1) == 1);
      default: rdy = 1;
    endcase
    rdy_cnt++;
    out_ready = rdy;
    if (out_valid && await_first) begin
      check("first_byte_latency", cyc - done_cyc, 1);
      await_first = 0;
    end
    if (out_valid) begin
      if (rdy) begin
        check("byte_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("byte", out_data, exp_q.pop_front());
        n_bytes++;
      end else begin
        held_v = 1;
        held_d = out_data;
      end
    end
  endtask

  task automatic run_until_starts(input int target, input int limit);
    for (int i = 0; i < limit && n_starts < target; i++) cycle();
    check("start_count", n_starts, target);
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    en = 1'b0;
    step = 9'd0;
    cordic_done = 1'b1;
    cordic_sine = 16'h0;
    cordic_cosine = 16'h0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_start", cordic_start, 0);
    check("rst_angle", cordic_angle, 0);
    check("rst_timeout_err", timeout_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Directed sweep with fixed results, then wrap and clamp steps.
    fixed_vals = 1;
    rdy_mode = 0;
    step_q = '{90, 90, 90, 90, 20, 350, 350, 400};
    en = 1'b1;
    cycle();
    check("start_latency", n_starts, 1);
    run_until_starts(9, 600);

    // Next conversion never completes.
    to_next = 1;
    run_until_starts(11, 600);
    check("timeout_seen", to_checked, 1);
    check("timeout_sticky", timeout_err, 1);

    // Randomized values, steps, stale-done lengths, backpressure and enable gaps.
    fixed_vals = 0;
    rdy_mode = 1;
    for (int k = 0; k < 30; k++) begin
      en = ($urandom_range(0, 3) != 0);
      repeat (20) cycle();
    end

    // Reset while the second byte of a packet is on the bus.
    en = 1'b1;
    rdy_mode = 2;
    for (int i = 0; i < 400 && !(out_valid && (n_bytes % PKT) == 1); i++) cycle();
    @(posedge clk);
    #1;
    check("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("reset_valid_drop", out_valid, 0);
    check("reset_busy_drop", busy, 0);
    check("reset_data_drop", out_data, 0);
    exp_q.delete();
    step_q.delete();
    exp_angle = 0;
    pend = 0;
    held_v = 0;
    await_first = 0;
    n_bytes = 0;
    cordic_done = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_clears_timeout", timeout_err, 0);
    rst_n = 1'b1;
    base = n_starts;
    cycle();
    check("restart_latency", n_starts, base + 1);
    rdy_mode = 1;
    run_until_starts(base + 6, 600);

    // Drain and stop.
    en = 1'b0;
    for (int i = 0; i < 600 && busy; i++) cycle();
    cycle();
    check("stop_busy", busy, 0);
    check("stop_valid", out_valid, 0);
    check("all_bytes_delivered", exp_q.size(), 0);
    check("whole_packets", n_bytes % PKT, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
